mul8u_product_accumulator: RTL
==============================

Name: mul8u_product_accumulator

Overview:
- Downstream consumer of the 8x8 unsigned approximate multiplier: accepts its 16-bit products one per beat and accumulates a programmable-length sum (dot product).
- Lets the approximate multiplier be evaluated in a MAC context: accumulated error over a vector, not per-product error only.
- Registered input/output valid/ready handshakes; the multiplier itself stays combinational upstream.

Parameters:
- PROD_W, 16, product width; matches multiplier output O.
- ACC_W, 32, accumulator width; must be >= PROD_W.
- LEN_W, 8, width of vector-length field; max vector length 2^LEN_W-1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a new accumulation; sampled only in IDLE.
- len  input  LEN_W  number of products to accumulate; latched on accepted start.
- in_valid  input  1  upstream product valid.
- in_ready  output  1  block accepts a product this cycle.
- in_prod  input  PROD_W  product from multiplier (unsigned).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_acc  output  ACC_W  accumulated sum.
- out_count  output  LEN_W  number of products accumulated.
- overflow  output  1  sticky: carry out of ACC_W occurred during this accumulation.
- busy  output  1  high in ACCUM or DONE.

Behaviour:
- Reset (rst=1 at clock edge, any state, including mid-accumulation): state=IDLE, acc=0, count=0, len_q=0, overflow=0. Outputs after reset: in_ready=0, out_valid=0, out_acc=0, out_count=0, overflow=0, busy=0. Any partial sum is discarded.
- FSM states: IDLE, ACCUM, DONE. in_ready=1 only in ACCUM; out_valid=1 only in DONE. All outputs come directly from registers/state decode; there is no combinational path from in_* to out_*.
- IDLE:
  - start=1, len!=0: latch len_q=len, clear acc/count/overflow, go to ACCUM.
  - start=1, len==0: clear acc/count/overflow, go directly to DONE (empty result, out_acc=0).
  - start=0: stay in IDLE.
- ACCUM, beat accepted (in_valid & in_ready):
  - acc <= (acc + zero-extend(in_prod)) mod 2^ACC_W; count <= count+1.
  - If the addition carries out of ACC_W, overflow <= 1 (sticky until next start or reset).
  - If count+1 == len_q, go to DONE.
- ACCUM, in_valid=0: hold state; no timeout.
- Latency: out_valid rises on the cycle after the final accepted beat. Back-to-back beats are accepted every cycle (throughput 1 product/clk).
- DONE:
  - out_acc=acc, out_count=count, overflow held stable while out_valid=1 and out_ready=0.
  - out_valid & out_ready: go to IDLE; acc/count keep their values until the next start.
- start is ignored in ACCUM and DONE. start=1 in the same cycle DONE completes is also ignored; a new start is sampled from IDLE, so the minimum gap between results is one IDLE cycle.
- in_valid is ignored outside ACCUM: no products are consumed and in_ready stays 0.
- Width rule: unsigned arithmetic throughout; in_prod zero-extended to ACC_W; no saturation (wrap + flag).

Test Plan:
- Basic: start, len=3; products 0x0001, 0x00FF, 0xFE01 on consecutive cycles, out_ready=1 -> out_valid one cycle after third beat, out_acc=0x0000FF01, out_count=3, overflow=0, then IDLE.
- Bubbles/backpressure: len=2; products 0x1000 and 0x2000 with 3 idle cycles between; hold out_ready=0 for 5 cycles -> out_acc=0x00003000 stable throughout, out_valid held, in_ready=0 while in DONE.
- Zero length: start with len=0 -> out_valid next cycle, out_acc=0, out_count=0; no beats consumed even with in_valid=1.
- Overflow (ACC_W=16 build): len=2; products 0xFFFF and 0x0002 -> out_acc=0x0001, overflow=1; the next run with len=1, product 0x0005 -> out_acc=0x0005, overflow=0.
- Reset mid-operation: len=4; after 2 beats assert rst for 1 cycle -> all outputs 0, IDLE; following run with len=1, product 0x0007 -> out_acc=7, out_count=1.
- Full-length stream: len=255; all products 0xFE01 (255*255), in_valid continuous -> 255 beats accepted in 255 cycles, out_acc=0x00FD02FF, overflow=0; start pulses during ACCUM have no effect.

Source files
------------

// File: rtl/mul8u_product_accumulator.sv
// mul8u_product_accumulator
// Accumulates a programmable-length run of unsigned products coming from the
// 8x8 approximate multiplier, so that its error can be judged over a whole
// dot product rather than one product at a time.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   start      begin a new accumulation (sampled only in IDLE)
//   len        number of products to accumulate, latched on start
//   in_valid   upstream product valid
//   in_ready   product accepted this cycle (high only in ACCUM)
//   in_prod    unsigned product from the multiplier
//   out_valid  result valid (high only in DONE)
//   out_ready  downstream accepts the result
//   out_acc    accumulated sum, wraps modulo 2^ACC_W
//   out_count  number of products accumulated
//   overflow   sticky carry out of ACC_W during this accumulation
//   busy       high in ACCUM or DONE
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for start; previous result still on out_acc
// ACCUM | accepting products until len_q of them have arrived
// DONE  | result presented, waiting for out_ready
module mul8u_product_accumulator #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 32,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [LEN_W-1:0]  out_count,
  output logic              overflow,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [LEN_W-1:0]   count_q, count_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovf_q, ovf_d;

  // One extra bit on the adder exposes the carry out of ACC_W.
  logic [ACC_W:0]     sum;
  logic [LEN_W-1:0]   count_inc;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    count_d   = count_q;
    len_d     = len_q;
    ovf_d     = ovf_q;
    sum       = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod};
    count_inc = count_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          if (len != '0) begin
            len_d   = len;
            state_d = S_ACCUM;
          end else begin
            // Empty vector: report a zero result straight away.
            state_d = S_DONE;
          end
        end
      end
      S_ACCUM: begin
        if (in_valid) begin
          acc_d   = sum[ACC_W-1:0];
          count_d = count_inc;
          if (sum[ACC_W]) begin
            ovf_d = 1'b1;
          end
          if (count_inc == len_q) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        // start is deliberately not looked at here; a new run needs IDLE.
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      count_q <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
    end
  end

  // Everything below is state decode or a straight register; no path from
  // the input side reaches the output side within a cycle.
  assign in_ready  = (state_q == S_ACCUM);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_acc   = acc_q;
  assign out_count = count_q;
  assign overflow  = ovf_q;

endmodule
